// File: rtl/popcount_scheduler.sv
// Round-robin front end sharing one popcount counter among REQ_N requesters.
// Issue is registered one cycle after transfer; results are routed back through an in-order tag FIFO.
module popcount_scheduler #(
    parameter int DATA_W  = 16,
    parameter int REQ_N   = 4,
    parameter int MAX_OUT = 8,
    localparam int CNT_W  = $clog2(DATA_W) + 2,
    localparam int ID_W   = $clog2(REQ_N)
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    input  logic [REQ_N-1:0][DATA_W-1:0]   req_data_i,
    input  logic [REQ_N-1:0]               req_val_i,
    output logic [REQ_N-1:0]               req_ready_o,
    output logic [DATA_W-1:0]              pc_data_o,
    output logic                           pc_data_val_o,
    input  logic [CNT_W-1:0]               pc_data_i,
    input  logic                           pc_data_val_i,
    output logic [CNT_W-1:0]               res_data_o,
    output logic [ID_W-1:0]                res_id_o,
    output logic                           res_val_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OUT_W = $clog2(MAX_OUT) + 1;
    localparam logic [OUT_W-1:0] OUT_MAX    = OUT_W'(MAX_OUT);
    localparam logic [ID_W-1:0]  LAST_RESET = ID_W'(REQ_N - 1);

    logic [1:0]        rst_sync_q, rst_sync_d;
    logic              rst_s;

    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [OUT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0]   tag_mem_q [MAX_OUT];
    logic [ID_W-1:0]   tag_mem_d [MAX_OUT];

    logic [DATA_W-1:0] pc_data_q, pc_data_d;
    logic              pc_val_q, pc_val_d;
    logic [CNT_W-1:0]  res_data_q, res_data_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic              res_val_q, res_val_d;
    logic              err_q, err_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand_id;
    int                cand;
    logic              can_issue;
    logic              xfer;
    logic              pop;

    // Assertion follows arst_i immediately; release is delayed two edges so every flop
    // below sees the same deassertion edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b0};
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_s = rst_sync_q[1];

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_id     = '0;
        for (int i = 1; i <= REQ_N; i++) begin
            cand    = (int'(last_grant_q) + i) % REQ_N;
            cand_id = ID_W'(cand);
            if (!grant_found && req_val_i[cand_id]) begin
                grant_found = 1'b1;
                grant_idx   = cand_id;
            end
        end
    end

    // Stall is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign can_issue = !rst_s && (cnt_q != OUT_MAX);
    assign xfer      = can_issue && grant_found;
    assign pop       = pc_data_val_i && (cnt_q != '0);

    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tag_mem_d    = tag_mem_q;
        cnt_d        = cnt_q;
        pc_val_d     = xfer;
        pc_data_d    = pc_data_q;
        res_val_d    = pop;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        err_d        = err_q | (pc_data_val_i && (cnt_q == '0));

        if (xfer) begin
            last_grant_d        = grant_idx;
            pc_data_d           = req_data_i[grant_idx];
            tag_mem_d[wr_ptr_q] = grant_idx;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            res_data_d = pc_data_i;
            res_id_d   = tag_mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end

        case ({xfer, pop})
            2'b10:   cnt_d = cnt_q + OUT_W'(1);
            2'b01:   cnt_d = cnt_q - OUT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_s) begin
        if (rst_s) begin
            last_grant_q <= LAST_RESET;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_mem_q[i] <= '0;
            end
            pc_val_q     <= 1'b0;
            pc_data_q    <= '0;
            res_val_q    <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_mem_q    <= tag_mem_d;
            pc_val_q     <= pc_val_d;
            pc_data_q    <= pc_data_d;
            res_val_q    <= res_val_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            err_q        <= err_d;
        end
    end

    assign pc_data_o     = pc_data_q;
    assign pc_data_val_o = pc_val_q;
    assign res_data_o    = res_data_q;
    assign res_id_o      = res_id_q;
    assign res_val_o     = res_val_q;
    assign busy_o        = (cnt_q != '0);
    assign err_o         = err_q;

endmodule

// File: tb/tb_popcount_scheduler.sv
// Directed bench for popcount_scheduler with a fixed-latency popcount counter model.
module tb_popcount_scheduler;

    localparam int DATA_W  = 16;
    localparam int REQ_N   = 4;
    localparam int MAX_OUT = 8;
    localparam int CNT_W   = 6;
    localparam int ID_W    = 2;
    localparam int LAT     = 3;

    logic                         clk;
    logic                         arst;
    logic [REQ_N-1:0][DATA_W-1:0] req_data;
    logic [REQ_N-1:0]             req_val;
    logic [REQ_N-1:0]             req_ready;
    logic [DATA_W-1:0]            pc_data_o;
    logic                         pc_val_o;
    logic [CNT_W-1:0]             pc_data_i;
    logic                         pc_val_i;
    logic [CNT_W-1:0]             res_data;
    logic [ID_W-1:0]              res_id;
    logic                         res_val;
    logic                         busy;
    logic                         err;

    logic                         cnt_en;
    logic                         c_val, m_val;
    logic [CNT_W-1:0]             c_dat, m_dat;
    logic                         pv [LAT];
    logic [CNT_W-1:0]             pd [LAT];

    int total = 0;
    int bad   = 0;
    int g_q[$];
    int e_pc[$];
    int r_id[$];
    int r_dat[$];
    int exp_g[7] = '{3, 3, 3, 1, 3, 1, 3};
    int exp_pc[4] = '{16, 1, 4, 8};

    assign pc_val_i  = cnt_en ? c_val : m_val;
    assign pc_data_i = cnt_en ? c_dat : m_dat;

    popcount_scheduler #(
        .DATA_W (DATA_W),
        .REQ_N  (REQ_N),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .req_data_i   (req_data),
        .req_val_i    (req_val),
        .req_ready_o  (req_ready),
        .pc_data_o    (pc_data_o),
        .pc_data_val_o(pc_val_o),
        .pc_data_i    (pc_data_i),
        .pc_data_val_i(pc_val_i),
        .res_data_o   (res_data),
        .res_id_o     (res_id),
        .res_val_o    (res_val),
        .busy_o       (busy),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Popcount counter: fixed latency, in order, no backpressure.
    initial begin
        for (int i = 0; i < LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        c_val = 1'b0;
        c_dat = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = LAT - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = cnt_en && pc_val_o;
            pd[0] = CNT_W'($countones(pc_data_o));
            c_val = cnt_en && pv[LAT-1];
            c_dat = pd[LAT-1];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < REQ_N; i++) begin
            if (req_ready[i] && req_val[i]) begin
                g_q.push_back(i);
                e_pc.push_back($countones(req_data[i]));
            end
        end
        if (res_val) begin
            r_id.push_back(int'(res_id));
            r_dat.push_back(int'(res_data));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        g_q.delete();
        e_pc.delete();
        r_id.delete();
        r_dat.delete();
    endtask

    initial begin
        arst   = 1'b1;
        cnt_en = 1'b0;
        m_val  = 1'b0;
        m_dat  = '0;
        req_val = 4'hF;
        req_data[0] = 16'hFFFF;
        req_data[1] = 16'h0001;
        req_data[2] = 16'h00F0;
        req_data[3] = 16'hA5A5;
        tick(2);
        check("rst_ready",    32'(req_ready), 32'h0);
        check("rst_pc_val",   32'(pc_val_o),  32'h0);
        check("rst_pc_data",  32'(pc_data_o), 32'h0);
        check("rst_res_val",  32'(res_val),   32'h0);
        check("rst_res_data", 32'(res_data),  32'h0);
        check("rst_res_id",   32'(res_id),    32'h0);
        check("rst_busy",     32'(busy),      32'h0);
        check("rst_err",      32'(err),       32'h0);
        req_val = 4'h0;
        arst = 1'b0;
        tick(3);

        // Stray result with nothing outstanding.
        m_dat = 6'd3;
        m_val = 1'b1;
        tick(1);
        m_val = 1'b0;
        check("stray_err",     32'(err),     32'h1);
        check("stray_res_val", 32'(res_val), 32'h0);
        check("stray_busy",    32'(busy),    32'h0);
        tick(2);
        check("stray_err_sticky", 32'(err),     32'h1);
        check("stray_res_val2",   32'(res_val), 32'h0);
        arst = 1'b1;
        #1;
        check("rearst_err", 32'(err), 32'h0);
        tick(1);
        arst = 1'b0;
        tick(3);

        // All four requesters streaming.
        cnt_en = 1'b1;
        clear_q();
        req_val = 4'hF;
        #1;
        check("rr_first_ready", 32'(req_ready), 32'h1);
        tick(1);
        check("rr_pc_val",  32'(pc_val_o),  32'h1);
        check("rr_pc_data", 32'(pc_data_o), 32'hFFFF);
        check("rr_ready2",  32'(req_ready), 32'h2);
        tick(7);
        req_val = 4'h0;
        tick(8);
        check("rr_grant_cnt", 32'(g_q.size()),  32'd8);
        check("rr_res_cnt",   32'(r_id.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < g_q.size())  check($sformatf("rr_grant%0d", i), 32'(g_q[i]),  32'(i % 4));
            if (i < r_id.size()) check($sformatf("rr_id%0d", i),    32'(r_id[i]),  32'(i % 4));
            if (i < r_dat.size()) check($sformatf("rr_pc%0d", i),   32'(r_dat[i]), 32'(exp_pc[i % 4]));
        end
        check("rr_busy_idle", 32'(busy),     32'h0);
        check("rr_hold_data", 32'(res_data), 32'd8);
        check("rr_hold_id",   32'(res_id),   32'd3);
        check("rr_hold_val",  32'(res_val),  32'h0);

        // Result path stalled: fill the tag FIFO.
        cnt_en = 1'b0;
        clear_q();
        req_data[2] = 16'h0F0F;
        req_val = 4'b0100;
        tick(12);
        check("stall_grants", 32'(g_q.size()), 32'd8);
        check("stall_ready",  32'(req_ready),  32'h0);
        check("stall_busy",   32'(busy),       32'h1);
        m_dat = 6'd8;
        m_val = 1'b1;
        #1;
        check("stall_pop_same_cycle", 32'(req_ready), 32'h0);
        tick(1);
        m_val = 1'b0;
        check("stall_ready_after_pop", 32'(req_ready), 32'h4);
        check("stall_res_val",  32'(res_val),  32'h1);
        check("stall_res_id",   32'(res_id),   32'd2);
        check("stall_res_data", 32'(res_data), 32'd8);
        tick(1);
        check("stall_refill_ready",  32'(req_ready),  32'h0);
        check("stall_refill_grants", 32'(g_q.size()), 32'd9);
        req_val = 4'h0;
        m_val = 1'b1;
        tick(8);
        m_val = 1'b0;
        tick(2);
        check("stall_drain_busy", 32'(busy),        32'h0);
        check("stall_drain_res",  32'(r_id.size()), 32'd9);
        check("stall_err",        32'(err),         32'h0);

        // Requester 3 alone, then requester 1 joins.
        cnt_en = 1'b1;
        clear_q();
        req_val = 4'b1000;
        tick(3);
        req_val = 4'b1010;
        tick(4);
        req_val = 4'h0;
        tick(8);
        check("alt_grant_cnt", 32'(g_q.size()),  32'd7);
        check("alt_res_cnt",   32'(r_id.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < g_q.size())  check($sformatf("alt_grant%0d", i), 32'(g_q[i]),  32'(exp_g[i]));
            if (i < r_id.size()) check($sformatf("alt_id%0d", i),    32'(r_id[i]), 32'(exp_g[i]));
        end

        // Reset with five tags outstanding.
        cnt_en = 1'b0;
        clear_q();
        req_data[0] = 16'h00FF;
        req_val = 4'b0001;
        tick(5);
        req_val = 4'h0;
        check("mid_outstanding", 32'(g_q.size()), 32'd5);
        check("mid_busy",        32'(busy),       32'h1);
        req_val = 4'b0001;
        arst = 1'b1;
        #1;
        check("mid_rst_ready",    32'(req_ready), 32'h0);
        check("mid_rst_pc_val",   32'(pc_val_o),  32'h0);
        check("mid_rst_pc_data",  32'(pc_data_o), 32'h0);
        check("mid_rst_res_val",  32'(res_val),   32'h0);
        check("mid_rst_res_data", 32'(res_data),  32'h0);
        check("mid_rst_res_id",   32'(res_id),    32'h0);
        check("mid_rst_busy",     32'(busy),      32'h0);
        check("mid_rst_err",      32'(err),       32'h0);
        req_val = 4'h0;
        tick(1);
        arst = 1'b0;
        tick(3);
        clear_q();
        m_dat = 6'd5;
        m_val = 1'b1;
        tick(2);
        m_val = 1'b0;
        tick(1);
        check("stale_err",  32'(err),         32'h1);
        check("stale_res",  32'(r_id.size()), 32'd0);
        check("stale_busy", 32'(busy),        32'h0);
        cnt_en = 1'b1;
        req_data[0] = 16'h0003;
        req_val = 4'b0001;
        tick(1);
        req_val = 4'h0;
        tick(8);
        check("post_rst_res_cnt", 32'(r_id.size()), 32'd1);
        if (r_id.size() > 0) begin
            check("post_rst_id",   32'(r_id[0]),  32'd0);
            check("post_rst_data", 32'(r_dat[0]), 32'd2);
        end

        // Random valids and data against the issue-order model.
        clear_q();
        for (int c = 0; c < 300; c++) begin
            for (int r = 0; r < REQ_N; r++) req_data[r] = DATA_W'($urandom);
            req_val = REQ_N'($urandom_range(0, 15));
            tick(1);
        end
        req_val = 4'h0;
        tick(10);
        check("rand_count", 32'(r_id.size()), 32'(g_q.size()));
        for (int i = 0; i < r_id.size() && i < g_q.size(); i++) begin
            check($sformatf("rand_id%0d", i), 32'(r_id[i]),  32'(g_q[i]));
            check($sformatf("rand_pc%0d", i), 32'(r_dat[i]), 32'(e_pc[i]));
        end
        check("rand_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/popcount_scheduler.md
POPCOUNT_SCHEDULER -- requirements
Module: popcount_scheduler

Interface
REQ-001 Parameter DATA_W, default 16, width of each requester data word and of the shared counter input.
REQ-002 Parameter REQ_N, default 4, number of requesters (2..16).
REQ-003 Parameter MAX_OUT, default 8, power of two, maximum counter transactions in flight (tag FIFO depth).
REQ-004 Localparam CNT_W = $clog2(DATA_W)+2, result width; ID_W = $clog2(REQ_N).
REQ-005 Port clk_i  input  1  single clock; all logic on rising edge.
REQ-006 Port arst_i  input  1  reset, asynchronous and active-high.
REQ-007 Port req_data_i  input  REQ_N x DATA_W  per-requester data word.
REQ-008 Port req_val_i  input  REQ_N  per-requester valid.
REQ-009 Port req_ready_o  output  REQ_N  per-requester ready; transfer when val and ready are both high.
REQ-010 Port pc_data_o  output  DATA_W  word issued to the shared popcount counter.
REQ-011 Port pc_data_val_o  output  1  issue strobe to the counter.
REQ-012 Port pc_data_i  input  CNT_W  result returned by the counter (in order, fixed unknown latency, no backpressure).
REQ-013 Port pc_data_val_i  input  1  result strobe from the counter.
REQ-014 Port res_data_o  output  CNT_W  routed result.
REQ-015 Port res_id_o  output  ID_W  requester index owning res_data_o.
REQ-016 Port res_val_o  output  1  result strobe, single-cycle per result.
REQ-017 Port busy_o  output  1  high while in-flight count is non-zero.
REQ-018 Port err_o  output  1  sticky: counter returned a result with no tag outstanding.

Function
REQ-019 Arbitration SHALL be round-robin over requesters with req_val_i high, searching from last_grant+1 upward with wrap from REQ_N-1 to 0.
REQ-020 At most one req_ready_o bit SHALL be high per cycle; it is the arbitration winner, asserted combinationally in the same cycle as its req_val_i.
REQ-021 All req_ready_o SHALL be low when in-flight count equals MAX_OUT (stall), judged on the registered count; a result popped in that cycle does not permit an issue in the same cycle.
REQ-022 last_grant SHALL update only on a completed transfer; idle cycles and stalls leave it unchanged.
REQ-023 A transfer in cycle T SHALL produce pc_data_val_o=1 with pc_data_o = granted req_data_i in cycle T+1 (registered); pc_data_val_o=0 otherwise.
REQ-024 On each transfer the winner index SHALL be pushed into a MAX_OUT-deep tag FIFO; on each pc_data_val_i the head tag SHALL be popped.
REQ-025 pc_data_val_i in cycle U with a non-empty FIFO SHALL produce res_val_o=1, res_data_o=pc_data_i, res_id_o=popped tag in cycle U+1 (registered).
REQ-026 pc_data_val_i with an empty FIFO (including same-cycle push into empty) SHALL drop the result, assert err_o from the next cycle, and leave FIFO and count unchanged.
REQ-027 Simultaneous push and pop SHALL leave the in-flight count unchanged; FIFO pointers wrap modulo MAX_OUT.
REQ-028 In-flight count SHALL be $clog2(MAX_OUT)+1 bits and never exceed MAX_OUT or underflow 0.
REQ-029 res_data_o and res_id_o SHALL hold their last value when res_val_o is low.
REQ-030 err_o SHALL remain high until reset.

Reset
REQ-031 While arst_i is high: req_ready_o=0, pc_data_val_o=0, pc_data_o=0, res_val_o=0, res_data_o=0, res_id_o=0, busy_o=0, err_o=0, FIFO empty, count=0, last_grant=REQ_N-1 (requester 0 highest priority first).
REQ-032 Reset asserted mid-operation SHALL discard all outstanding tags; counter results arriving after reset release with an empty FIFO follow REQ-026.
REQ-033 Reset release SHALL be synchronised internally so all state leaves reset on the same clock edge.

Verification
REQ-034 All four req_val_i held high, counter with 3-cycle latency: grants 0,1,2,3,0,... one per cycle; res_id_o follows the same order; res_data_o = popcount of each word (e.g. 16'hFFFF -> 16, 16'h0001 -> 1).
REQ-035 Counter result path stalled (no pc_data_val_i), requester 2 valid: exactly 8 transfers, then req_ready_o=0 and busy_o=1; one pc_data_val_i -> one further transfer allowed from the next cycle.
REQ-036 Only requester 3 valid then requester 1 added: grant stays 3 until 1 asserts, then alternates 1,3,1,3.
REQ-037 pc_data_val_i pulsed with nothing outstanding after reset -> err_o=1 next cycle, res_val_o stays 0, busy_o stays 0.
REQ-038 arst_i pulsed with 5 tags outstanding -> all outputs 0 immediately; subsequent requester 0 transfer issues normally and its result returns with res_id_o=0 once stale results are cleared.
REQ-039 Randomised valid/latency run against a reference model: every accepted word yields exactly one res_val_o with matching id and popcount, in issue order.
